// File: rtl/present_bus_pkg.sv
// rtl/present_bus_pkg.sv - Register map, state encoding and bus command helpers for the PRESENT host sequencer
package present_bus_pkg;

   // Peripheral register map
   localparam logic [3:0] ADDR_CTRL    = 4'd0;  // bit 0 = load
   localparam logic [3:0] ADDR_KEY_LO  = 4'd1;  // key[15:0] in low half
   localparam logic [3:0] ADDR_KEY_MID = 4'd2;  // key[47:16]
   localparam logic [3:0] ADDR_KEY_HI  = 4'd3;  // key[79:48]
   localparam logic [3:0] ADDR_BLK_LO  = 4'd4;  // block[31:0]
   localparam logic [3:0] ADDR_BLK_HI  = 4'd5;  // block[63:32]
   localparam logic [3:0] ADDR_RES_LO  = 4'd6;  // result[31:0]
   localparam logic [3:0] ADDR_RES_HI  = 4'd7;  // result[63:32]
   localparam logic [3:0] ADDR_MODE    = 4'd8;  // bit 0 = decrypt

   typedef enum logic [3:0] {
      ST_IDLE, ST_WK3, ST_WK2, ST_WK1, ST_WD5, ST_WD4, ST_WC8, ST_WL0,
      ST_LCLR, ST_WAIT, ST_RD7, ST_RD6, ST_CAP, ST_DONE
   } state_t;

   typedef struct packed {
      logic        cs_n;
      logic        write_n;
      logic        read_n;
      logic [3:0]  addr;
      logic [31:0] dat;
   } bus_cmd_t;

   localparam bus_cmd_t BUS_IDLE = '{cs_n: 1'b1, write_n: 1'b1, read_n: 1'b1, addr: 4'h0, dat: 32'h0};

   // Selected with both strobes high: drops the peripheral's load bit without a write
   localparam bus_cmd_t BUS_RELEASE = '{cs_n: 1'b0, write_n: 1'b1, read_n: 1'b1, addr: ADDR_CTRL, dat: 32'h0};

   function automatic bus_cmd_t bus_write(input logic [3:0] addr, input logic [31:0] dat);
      return '{cs_n: 1'b0, write_n: 1'b0, read_n: 1'b1, addr: addr, dat: dat};
   endfunction

   function automatic bus_cmd_t bus_read(input logic [3:0] addr);
      return '{cs_n: 1'b0, write_n: 1'b1, read_n: 1'b0, addr: addr, dat: 32'h0};
   endfunction

endpackage

// File: rtl/present_host_sequencer_if.sv
// rtl/present_host_sequencer_if.sv - Register bus between the host sequencer and the PRESENT peripheral
// Signals: oChipselect_n/oWrite_n/oRead_n active-low strobes, oAddress, oDat (write data) from host;
//          iDat (registered read data, valid the cycle after a read strobe) from peripheral.
interface present_host_sequencer_if;
   import present_bus_pkg::*;

   logic        oChipselect_n;
   logic        oWrite_n;
   logic        oRead_n;
   logic [3:0]  oAddress;
   logic [31:0] oDat;
   logic [31:0] iDat;

   modport master (
      output oChipselect_n, oWrite_n, oRead_n, oAddress, oDat,
      input  iDat
   );

   modport slave (
      input  oChipselect_n, oWrite_n, oRead_n, oAddress, oDat,
      output iDat
   );
endinterface

// File: rtl/present_wait_timer.sv
// rtl/present_wait_timer.sv - Loadable down-counter that flags the last cycle of the peripheral wait
// Ports: clk, i_rst (sync, high); i_load/i_load_value reload the count; o_expired high while count==1.
module present_wait_timer
   import present_bus_pkg::*;
#(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_value,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   // Loaded with N on entry to WAIT, so count==1 marks the Nth wait cycle
   assign o_expired = (r_count == WIDTH'(1));

endmodule

// File: rtl/present_host_sequencer.sv
// rtl/present_host_sequencer.sv - Sequences key/block/mode writes, waits out the round latency, reads the result
// Ports: clk, iReset (sync, high); iStart/iKey/iBlock/iMode request (latched in IDLE);
//        oBusy/oDone/oResult status; bus (master modport) peripheral register bus, all outputs registered.
module present_host_sequencer
   import present_bus_pkg::*;
#(
   parameter int WAIT_CYCLES = 40
) (
   input  logic                     clk,
   input  logic                     iReset,
   input  logic                     iStart,
   input  logic [79:0]              iKey,
   input  logic [63:0]              iBlock,
   input  logic                     iMode,
   output logic                     oBusy,
   output logic                     oDone,
   output logic [63:0]              oResult,
   present_host_sequencer_if.master bus
);

   localparam int TW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   state_t      r_state;
   bus_cmd_t    r_bus;
   logic [79:0] r_key;
   logic [63:0] r_block;
   logic        r_mode;
   logic        w_timer_load;
   logic        w_timer_expired;

   assign w_timer_load = (r_state == ST_LCLR);

   present_wait_timer #(
      .WIDTH(TW)
   ) u_wait_timer (
      .clk          (clk),
      .i_rst        (iReset),
      .i_load       (w_timer_load),
      .i_load_value (TW'(WAIT_CYCLES)),
      .o_expired    (w_timer_expired)
   );

   // Each branch computes the bus command for the state being entered,
   // so the registered bus lines up with r_state.
   always_ff @(posedge clk) begin
      if (iReset) begin
         r_state <= ST_IDLE;
         r_bus   <= BUS_IDLE;
         r_key   <= '0;
         r_block <= '0;
         r_mode  <= 1'b0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oResult <= '0;
      end else begin
         r_bus <= BUS_IDLE;
         oDone <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (iStart) begin
                  r_key   <= iKey;
                  r_block <= iBlock;
                  r_mode  <= iMode;
                  oBusy   <= 1'b1;
                  r_state <= ST_WK3;
                  r_bus   <= bus_write(ADDR_KEY_HI, iKey[79:48]);
               end
            end
            ST_WK3: begin
               r_state <= ST_WK2;
               r_bus   <= bus_write(ADDR_KEY_MID, r_key[47:16]);
            end
            ST_WK2: begin
               r_state <= ST_WK1;
               r_bus   <= bus_write(ADDR_KEY_LO, {16'h0, r_key[15:0]});
            end
            ST_WK1: begin
               r_state <= ST_WD5;
               r_bus   <= bus_write(ADDR_BLK_HI, r_block[63:32]);
            end
            ST_WD5: begin
               r_state <= ST_WD4;
               r_bus   <= bus_write(ADDR_BLK_LO, r_block[31:0]);
            end
            ST_WD4: begin
               r_state <= ST_WC8;
               r_bus   <= bus_write(ADDR_MODE, {31'h0, r_mode});
            end
            ST_WC8: begin
               r_state <= ST_WL0;
               r_bus   <= bus_write(ADDR_CTRL, 32'h1);
            end
            ST_WL0: begin
               r_state <= ST_LCLR;
               r_bus   <= BUS_RELEASE;
            end
            ST_LCLR: begin
               if (WAIT_CYCLES == 0) begin
                  r_state <= ST_RD7;
                  r_bus   <= bus_read(ADDR_RES_HI);
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_timer_expired) begin
                  r_state <= ST_RD7;
                  r_bus   <= bus_read(ADDR_RES_HI);
               end
            end
            ST_RD7: begin
               r_state <= ST_RD6;
               r_bus   <= bus_read(ADDR_RES_LO);
            end
            ST_RD6: begin
               // iDat now carries the register-7 read issued in RD7
               oResult[63:32] <= iDat_w();
               r_state        <= ST_CAP;
            end
            ST_CAP: begin
               oResult[31:0] <= iDat_w();
               oDone         <= 1'b1;
               r_state       <= ST_DONE;
            end
            ST_DONE: begin
               oBusy   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               oBusy   <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   function automatic logic [31:0] iDat_w();
      return bus.iDat;
   endfunction

   assign bus.oChipselect_n = r_bus.cs_n;
   assign bus.oWrite_n      = r_bus.write_n;
   assign bus.oRead_n       = r_bus.read_n;
   assign bus.oAddress      = r_bus.addr;
   assign bus.oDat          = r_bus.dat;

endmodule

// File: tb/tb_present_host_sequencer.sv
// tb/tb_present_host_sequencer.sv - Directed self-checking bench for present_host_sequencer
module tb_present_host_sequencer;

   logic        clk = 1'b0;
   logic        iReset;
   logic        iStart;
   logic        sel;
   logic [79:0] iKey;
   logic [63:0] iBlock;
   logic        iMode;
   logic        start0, start1, busy0, busy1, done0, done1;
   logic [63:0] res0, res1;
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   present_host_sequencer_if bus0 ();
   present_host_sequencer_if bus1 ();

   assign start0 = iStart && !sel;
   assign start1 = iStart && sel;

   present_host_sequencer #(.WAIT_CYCLES(40)) dut0 (
      .clk(clk), .iReset(iReset), .iStart(start0), .iKey(iKey), .iBlock(iBlock), .iMode(iMode),
      .oBusy(busy0), .oDone(done0), .oResult(res0), .bus(bus0)
   );

   present_host_sequencer #(.WAIT_CYCLES(0)) dut1 (
      .clk(clk), .iReset(iReset), .iStart(start1), .iKey(iKey), .iBlock(iBlock), .iMode(iMode),
      .oBusy(busy1), .oDone(done1), .oResult(res1), .bus(bus1)
   );

   // Peripheral models: known PRESENT-80 vectors, result ready LAT cycles after load release
   logic        cs_n [2], wr_n [2], rd_n [2];
   logic [3:0]  adr [2];
   logic [31:0] wdat [2];
   logic [31:0] p_regs [2][16];
   logic        p_loaded [2] = '{1'b0, 1'b0};
   logic        p_ready [2]  = '{1'b0, 1'b0};
   int          p_cnt [2]    = '{0, 0};
   logic [63:0] p_res [2];
   logic [31:0] p_dat [2]    = '{32'h0, 32'h0};

   assign cs_n[0] = bus0.oChipselect_n;  assign cs_n[1] = bus1.oChipselect_n;
   assign wr_n[0] = bus0.oWrite_n;       assign wr_n[1] = bus1.oWrite_n;
   assign rd_n[0] = bus0.oRead_n;        assign rd_n[1] = bus1.oRead_n;
   assign adr[0]  = bus0.oAddress;       assign adr[1]  = bus1.oAddress;
   assign wdat[0] = bus0.oDat;           assign wdat[1] = bus1.oDat;
   assign bus0.iDat = p_dat[0];
   assign bus1.iDat = p_dat[1];

   function automatic logic [63:0] present_ref(input logic [79:0] k, input logic [63:0] b, input logic m);
      if (k == '0 && b == '0 && !m) return 64'h5579C1387B228445;
      if (k == '1 && b == '1 && !m) return 64'h3333DCD3213210D2;
      if (k == '0 && b == 64'h5579C1387B228445 && m) return 64'h0;
      return 64'hBAD00BADBAD00BAD ^ b;
   endfunction

   always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         p_dat[p] <= 32'h0;
         if (p_cnt[p] > 0) p_cnt[p] <= p_cnt[p] - 1;
         if (!cs_n[p] && !wr_n[p]) begin
            p_regs[p][adr[p]] <= wdat[p];
            if (adr[p] == 4'd0) begin
               p_loaded[p] <= wdat[p][0];
               p_ready[p]  <= 1'b0;
            end
         end else if (!cs_n[p] && rd_n[p] && adr[p] == 4'd0) begin
            p_loaded[p] <= 1'b0;
            p_ready[p]  <= p_loaded[p];
            p_res[p]    <= present_ref({p_regs[p][3], p_regs[p][2], p_regs[p][1][15:0]},
                                       {p_regs[p][5], p_regs[p][4]}, p_regs[p][8][0]);
            p_cnt[p]    <= (p == 0) ? 40 : 0;
         end else if (!cs_n[p] && !rd_n[p]) begin
            if (p_ready[p] && p_cnt[p] == 0)
               p_dat[p] <= (adr[p] == 4'd7) ? p_res[p][63:32] :
                           (adr[p] == 4'd6) ? p_res[p][31:0] : p_regs[p][adr[p]];
            else
               p_dat[p] <= 32'hDEADBEEF;
         end
      end
   end

   // Observation of the currently selected instance
   logic        obs_busy, obs_done;
   logic [63:0] obs_res;
   logic [38:0] obs_bus;
   assign obs_busy = sel ? busy1 : busy0;
   assign obs_done = sel ? done1 : done0;
   assign obs_res  = sel ? res1 : res0;
   assign obs_bus  = sel ? {bus1.oChipselect_n, bus1.oWrite_n, bus1.oRead_n, bus1.oAddress, bus1.oDat}
                         : {bus0.oChipselect_n, bus0.oWrite_n, bus0.oRead_n, bus0.oAddress, bus0.oDat};

   localparam logic [38:0] E_IDLE = {3'b111, 4'h0, 32'h0};

   function automatic logic [38:0] e_wr(input logic [3:0] a, input logic [31:0] d);
      return {3'b001, a, d};
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Launch one operation, change inputs after the launch cycle, check every bus cycle
   task automatic run_op(input string tag, input logic [79:0] k, input logic [63:0] b, input logic m,
                         input logic [79:0] k2, input logic [63:0] b2, input logic m2,
                         input logic [63:0] exp, input bit hold);
      int wc;
      wc = sel ? 0 : 40;
      iKey = k; iBlock = b; iMode = m; iStart = 1'b1;
      @(negedge clk);
      if (!hold) iStart = 1'b0;
      chk({tag, "/wk3"}, obs_bus, e_wr(4'd3, k[79:48]));
      chk({tag, "/busy"}, obs_busy, 1'b1);
      iKey = k2; iBlock = b2; iMode = m2;
      @(negedge clk); chk({tag, "/wk2"}, obs_bus, e_wr(4'd2, k[47:16]));
      @(negedge clk); chk({tag, "/wk1"}, obs_bus, e_wr(4'd1, {16'h0, k[15:0]}));
      @(negedge clk); chk({tag, "/wd5"}, obs_bus, e_wr(4'd5, b[63:32]));
      @(negedge clk); chk({tag, "/wd4"}, obs_bus, e_wr(4'd4, b[31:0]));
      @(negedge clk); chk({tag, "/wc8"}, obs_bus, e_wr(4'd8, {31'h0, m}));
      @(negedge clk); chk({tag, "/wl0"}, obs_bus, e_wr(4'd0, 32'h1));
      @(negedge clk); chk({tag, "/lclr"}, obs_bus[38:32], 7'b0110000);
      for (int i = 0; i < wc; i++) begin
         @(negedge clk);
         if (i == 0 || i == wc - 1) chk({tag, "/wait"}, {obs_busy, obs_bus}, {1'b1, E_IDLE});
      end
      @(negedge clk); chk({tag, "/rd7"}, obs_bus[38:32], 7'b0100111);
      @(negedge clk); chk({tag, "/rd6"}, obs_bus[38:32], 7'b0100110);
      @(negedge clk); chk({tag, "/cap"}, {obs_done, obs_bus}, {1'b0, E_IDLE});
      @(negedge clk);
      chk({tag, "/done"}, {obs_done, obs_busy}, 2'b11);
      chk({tag, "/result"}, obs_res, exp);
      chk({tag, "/done_bus"}, obs_bus, E_IDLE);
      @(negedge clk);
      chk({tag, "/idle"}, {obs_done, obs_busy}, 2'b00);
      chk({tag, "/hold_res"}, obs_res, exp);
   endtask

   initial begin
      bit seen_done;
      iReset = 1'b1; iStart = 1'b0; sel = 1'b0;
      iKey = '0; iBlock = '0; iMode = 1'b0;
      repeat (3) @(negedge clk);
      iReset = 1'b0;
      @(negedge clk);
      chk("reset0", {busy0, done0, res0}, 66'h0);
      chk("reset0_bus", obs_bus, E_IDLE);
      chk("reset1", {busy1, done1, res1}, 66'h0);
      chk("reset1_bus", {bus1.oChipselect_n, bus1.oWrite_n, bus1.oRead_n, bus1.oAddress, bus1.oDat}, E_IDLE);

      run_op("zero", '0, '0, 1'b0, '1, '1, 1'b1, 64'h5579C1387B228445, 1'b0);
      run_op("ones", '1, '1, 1'b0, '0, '0, 1'b1, 64'h3333DCD3213210D2, 1'b0);

      // Reset in the middle of WAIT
      iKey = '0; iBlock = '0; iMode = 1'b0; iStart = 1'b1;
      @(negedge clk); iStart = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_rst_busy", obs_busy, 1'b1);
      iReset = 1'b1;
      @(negedge clk); iReset = 1'b0;
      chk("rst_wait", {obs_busy, obs_done, obs_res}, 66'h0);
      chk("rst_wait_bus", obs_bus, E_IDLE);
      seen_done = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (obs_done || obs_busy || obs_bus !== E_IDLE) seen_done = 1'b1;
      end
      chk("rst_quiet", seen_done, 1'b0);
      run_op("after_rst", '0, '0, 1'b0, '1, '0, 1'b1, 64'h5579C1387B228445, 1'b0);

      run_op("decrypt", '0, 64'h5579C1387B228445, 1'b1, '1, '1, 1'b0, 64'h0, 1'b0);

      // Reset wins over start
      iReset = 1'b1; iStart = 1'b1;
      @(negedge clk); iReset = 1'b0; iStart = 1'b0;
      chk("rst_prio", {obs_busy, obs_bus}, {1'b0, E_IDLE});

      // Start held high: second launch from the IDLE after DONE with the new key
      run_op("hold1", '1, '1, 1'b0, '0, '0, 1'b0, 64'h3333DCD3213210D2, 1'b1);
      run_op("hold2", '0, '0, 1'b0, '0, '0, 1'b0, 64'h5579C1387B228445, 1'b0);

      // Zero-wait instance
      sel = 1'b1;
      run_op("nowait", '0, '0, 1'b0, '1, '1, 1'b1, 64'h5579C1387B228445, 1'b0);
      run_op("nowait1", '1, '1, 1'b0, '0, '0, 1'b1, 64'h3333DCD3213210D2, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
